// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: shared state encoding and packet constants for the frame streamer
package frame_stream_pkg;
  typedef enum logic [2:0] {IDLE, ARM, SETTLE, HEADER, FETCH, SEND, GAP, TRAILER} state_t;
  localparam int HDR_LEN = 3;
  localparam logic [7:0] DEF_SYNC = 8'hA5;
endpackage

// File: rtl/vs_edge_detect.sv
// vs_edge_detect: two-flop synchroniser plus rising-edge pulse, flops reset high so a held-high input gives no pulse
module vs_edge_detect (
  input  logic Clk,
  input  logic i_Reset,
  input  logic i_VS,
  output logic o_Rise
);
  logic [2:0] sh;
  always_ff @(posedge Clk) sh <= i_Reset ? 3'b111 : {sh[1:0], i_VS};
  assign o_Rise = sh[1] & ~sh[2];
endmodule

// File: rtl/frame_uart_streamer.sv
// frame_uart_streamer: on a VS capture, streams header, frame-buffer payload and checksum to a UART byte port
module frame_uart_streamer import frame_stream_pkg::*; #(
  parameter int BYTES_PER_FRAME = 9216,
  parameter int ADDR_W = 15,
  parameter int SETTLE_CLKS = 62500000,
  parameter int GAP_CLKS = 1085,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC
) (
  input  logic              Clk,
  input  logic              i_Reset,
  input  logic              i_VS,
  input  logic              i_Enable,
  input  logic              i_Continuous,
  output logic [ADDR_W-1:0] o_Read_Adress,
  input  logic [7:0]        i_RAM_Data,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Valid,
  input  logic              i_Tx_Ready,
  output logic              o_Frame_Indicator,
  output logic              o_Busy,
  output logic              o_Frame_Done,
  output logic [7:0]        o_Frame_Count
);
  localparam int TMAX = SETTLE_CLKS > GAP_CLKS ? SETTLE_CLKS : GAP_CLKS;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CLKS - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CLKS > 0 ? GAP_CLKS - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [1:0] HDR_LAST = 2'(HDR_LEN - 1);
  state_t state, nxt, ret, dest;
  logic cap, xfer, fph;
  logic [1:0] hidx;
  logic [TW-1:0] tmr;
  logic [7:0] data, csum;
  vs_edge_detect u_vs (.Clk(Clk), .i_Reset(i_Reset), .i_VS(i_VS), .o_Rise(cap));
  always_comb begin
    nxt = state;
    o_Tx_Valid = state inside {HEADER, SEND, TRAILER};
    o_Tx_Data = !o_Tx_Valid ? 8'h00 : state == SEND ? data : state == TRAILER ? csum :
                hidx == 2'd0 ? SYNC_BYTE : hidx == 2'd1 ? ~SYNC_BYTE : o_Frame_Count;
    xfer = o_Tx_Valid & i_Tx_Ready;
    o_Frame_Indicator = state == ARM;
    o_Busy = state != IDLE && state != ARM;
    dest = state == HEADER ? (hidx == HDR_LAST ? FETCH : HEADER) :
           state == SEND ? (o_Read_Adress == LAST_ADDR ? TRAILER : FETCH) :
           (i_Continuous & i_Enable) ? ARM : IDLE;
    case (state)
      IDLE:    if (i_Enable) nxt = ARM;
      ARM:     if (cap) nxt = SETTLE;
      SETTLE:  if (tmr == SET_LAST) nxt = HEADER;
      FETCH:   if (fph) nxt = SEND;
      GAP:     if (tmr == GAP_LAST) nxt = ret;
      default: if (xfer) nxt = GAP_CLKS > 0 ? GAP : dest;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      ret <= IDLE;
      tmr <= '0;
      hidx <= '0;
      fph <= 1'b0;
      o_Read_Adress <= '0;
      data <= '0;
      csum <= '0;
      o_Frame_Count <= '0;
      o_Frame_Done <= 1'b0;
    end else begin
      state <= nxt;
      if (xfer) ret <= dest;
      tmr <= (nxt == state && (state == SETTLE || state == GAP)) ? tmr + TW'(1) : '0;
      fph <= state == FETCH && !fph;
      if (state == FETCH && fph) data <= i_RAM_Data;
      if (state == ARM) begin
        csum <= '0;
        hidx <= '0;
        o_Read_Adress <= '0;
      end
      if (xfer && state == HEADER) hidx <= hidx == HDR_LAST ? 2'd0 : hidx + 2'd1;
      if (xfer && state == SEND) begin
        csum <= csum + data;
        o_Read_Adress <= o_Read_Adress == LAST_ADDR ? '0 : o_Read_Adress + ADDR_W'(1);
      end
      o_Frame_Done <= xfer && state == TRAILER;
      if (xfer && state == TRAILER) o_Frame_Count <= o_Frame_Count + 8'd1;
    end
  end
endmodule

// File: tb/tb_frame_uart_streamer.sv
// tb_frame_uart_streamer: table, random and corner-case checks of the streamer against a packet-level model
module tb_frame_uart_streamer;
  localparam int BPF = 4;
  localparam int AW = 3;
  localparam int SET = 10;
  localparam int GAPC = 2;
  localparam logic [7:0] SYNC = 8'hA5;
  typedef struct packed {
    logic [31:0] ram;
    logic [7:0]  csum;
    logic        extra;
  } vec_t;
  logic Clk = 0, i_Reset = 1, i_VS = 0, i_Enable = 0, i_Continuous = 0, i_Tx_Ready = 1;
  logic [AW-1:0] o_Read_Adress;
  logic [7:0] i_RAM_Data, o_Tx_Data, o_Frame_Count;
  logic o_Tx_Valid, o_Frame_Indicator, o_Busy, o_Frame_Done;
  logic [7:0] mem [0:7];
  logic [7:0] got [$];
  logic [7:0] pdata, exp_cnt;
  int checks = 0, errors = 0, done_cnt = 0, cyc = 0;
  bit hold_low = 0, rnd_rdy = 0, pend = 0;
  vec_t tbl [5];
  always #5 Clk = ~Clk;
  frame_uart_streamer #(
    .BYTES_PER_FRAME(BPF), .ADDR_W(AW), .SETTLE_CLKS(SET), .GAP_CLKS(GAPC), .SYNC_BYTE(SYNC)
  ) dut (
    .Clk(Clk), .i_Reset(i_Reset), .i_VS(i_VS), .i_Enable(i_Enable), .i_Continuous(i_Continuous),
    .o_Read_Adress(o_Read_Adress), .i_RAM_Data(i_RAM_Data), .o_Tx_Data(o_Tx_Data),
    .o_Tx_Valid(o_Tx_Valid), .i_Tx_Ready(i_Tx_Ready), .o_Frame_Indicator(o_Frame_Indicator),
    .o_Busy(o_Busy), .o_Frame_Done(o_Frame_Done), .o_Frame_Count(o_Frame_Count)
  );
  always @(posedge Clk) begin
    i_RAM_Data <= mem[o_Read_Adress];
    cyc <= cyc + 1;
  end
  always @(posedge Clk) begin
    #1;
    i_Tx_Ready = hold_low ? 1'b0 : rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (i_Reset) pend = 0;
    else begin
      if (pend) chk("hold_stable", {o_Tx_Valid, o_Tx_Data}, {1'b1, pdata});
      if (o_Tx_Valid && i_Tx_Ready) got.push_back(o_Tx_Data);
      if (o_Frame_Done) done_cnt++;
      pend = o_Tx_Valid && !i_Tx_Ready;
      pdata = o_Tx_Data;
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic load(input logic [31:0] r);
    for (int i = 0; i < BPF; i++) mem[i] = r[8*i +: 8];
  endtask
  task automatic vs_pulse();
    i_VS = 1;
    tick(4);
    i_VS = 0;
    tick(2);
  endtask
  task automatic wait_got(input int n, input string nm);
    int k = 0;
    while (got.size() < n && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    chk({nm, "_wait"}, k < 2000, 1);
  endtask
  task automatic wait_valid(input logic lvl, input string nm);
    int k = 0;
    @(negedge Clk);
    while (o_Tx_Valid !== lvl && k < 2000) begin
      @(negedge Clk);
      k++;
    end
    chk({nm, "_wait"}, k < 2000, 1);
  endtask
  task automatic wait_done(input string nm);
    int d0 = done_cnt, k = 0;
    while (done_cnt == d0 && k < 3000) begin
      @(negedge Clk);
      k++;
    end
    chk({nm, "_done"}, k < 3000, 1);
  endtask
  task automatic check_packet(input string nm, input logic [31:0] ram, input logic [7:0] cnt);
    logic [7:0] e [$];
    logic [7:0] s = 8'h00;
    e.push_back(SYNC);
    e.push_back(~SYNC);
    e.push_back(cnt);
    for (int i = 0; i < BPF; i++) begin
      e.push_back(ram[8*i +: 8]);
      s += ram[8*i +: 8];
    end
    e.push_back(s);
    chk({nm, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_b%0d", nm, i), i < got.size() ? {1'b0, got[i]} : 9'h100, {1'b0, e[i]});
  endtask
  initial begin
    int k, t0, t1, d0;
    logic [31:0] r;
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int k, t0, t1, d0;
    logic [31:0] r;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    exp_cnt = 0;
    tbl[0] = '{32'hFFFFFFFF, 8'hFC, 1'b0};
    tbl[1] = '{32'h00000000, 8'h00, 1'b1};
    tbl[2] = '{32'h017F8080, 8'h80, 1'b0};
    tbl[3] = '{32'h40302010, 8'hA0, 1'b0};
    tbl[4] = '{32'h0C0B0A09, 8'h2A, 1'b0};
    tick(3);
    @(negedge Clk);
    chk("reset_outputs", {o_Tx_Valid, o_Tx_Data, o_Busy, o_Frame_Indicator, o_Frame_Done, o_Frame_Count, o_Read_Adress}, 0);
    tick(1);
    i_Reset = 0;
    i_Enable = 1;
    tick(2);
    @(negedge Clk);
    chk("armed_indicator", {o_Frame_Indicator, o_Busy}, 2'b10);
    load(32'h04030201);
    got.delete();
    tick(1);
    i_VS = 1;
    k = 0;
    while (!o_Busy && k < 100) begin
      @(negedge Clk);
      k++;
    end
    chk("settle_entry", k < 100, 1);
    t0 = cyc;
    i_VS = 0;
    wait_valid(1'b1, "first_valid");
    t1 = cyc;
    chk("first_valid_latency", t1 - t0, SET);
    wait_valid(1'b0, "gap_fall");
    wait_valid(1'b1, "gap_rise");
    chk("gap_spacing", cyc - t1, GAPC + 1);
    wait_got(4, "stall_setup");
    hold_low = 1;
    wait_valid(1'b1, "stall_valid");
    chk("stall_byte", o_Tx_Data, 8'h02);
    repeat (5) begin
      @(negedge Clk);
      chk("stall_hold", {o_Tx_Valid, o_Tx_Data}, {1'b1, 8'h02});
    end
    hold_low = 0;
    wait_done("frameA");
    check_packet("frameA", 32'h04030201, exp_cnt);
    chk("frameA_csum", got.size() > 7 ? got[7] : 8'hxx, 8'h0A);
    exp_cnt++;
    tick(1);
    chk("frameA_count", o_Frame_Count, exp_cnt);
    tick(5);
    i_Continuous = 1;
    rnd_rdy = 1;
    for (int v = 0; v < 5; v++) begin
      load(tbl[v].ram);
      got.delete();
      d0 = done_cnt;
      vs_pulse();
      if (tbl[v].extra) begin
        vs_pulse();
        wait_got(5, "extra_send");
        vs_pulse();
      end
      wait_done($sformatf("vec%0d", v));
      check_packet($sformatf("vec%0d", v), tbl[v].ram, exp_cnt);
      chk($sformatf("vec%0d_csum", v), got.size() > 7 ? got[7] : 8'hxx, tbl[v].csum);
      exp_cnt++;
      if (tbl[v].extra) begin
        tick(60);
        chk("no_extra_packet", got.size(), 8);
        chk("single_done", done_cnt - d0, 1);
      end else tick(5);
    end
    for (int n = 0; n < 3; n++) begin
      r = $urandom;
      load(r);
      got.delete();
      vs_pulse();
      wait_done($sformatf("rand%0d", n));
      check_packet($sformatf("rand%0d", n), r, exp_cnt);
      exp_cnt++;
      tick(5);
    end
    chk("count_before_reset", o_Frame_Count, exp_cnt);
    i_Continuous = 0;
    load(32'h44332211);
    got.delete();
    vs_pulse();
    wait_got(4, "abort_setup");
    wait_valid(1'b1, "abort_valid");
    @(posedge Clk);
    #1;
    i_Reset = 1;
    i_VS = 1;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("reset_abort", {o_Tx_Valid, o_Busy, o_Frame_Indicator, o_Frame_Count}, 0);
    tick(2);
    i_Reset = 0;
    got.delete();
    tick(40);
    chk("no_packet_after_reset", got.size(), 0);
    chk("armed_after_reset", {o_Busy, o_Frame_Indicator}, 2'b01);
    i_VS = 0;
    tick(3);
    vs_pulse();
    wait_done("post_reset");
    check_packet("post_reset", 32'h44332211, 8'h00);
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
